// File: rtl/csa_byte_serial_add.sv
// Byte-serial wide adder controller: streams operand byte slices through an external
// carry-select csa_8 and folds the inter-slice carry back in to build a W-bit sum.
module csa_byte_serial_add #(
    parameter int unsigned N_BYTES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [8*N_BYTES-1:0]   in_a,
    input  logic [8*N_BYTES-1:0]   in_b,
    output logic [7:0]             add_a,
    output logic [7:0]             add_b,
    input  logic [7:0]             add_sum,
    input  logic                   add_carry,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [8*N_BYTES-1:0]   out_sum,
    output logic                   out_carry
);

    localparam int unsigned W        = 8 * N_BYTES;
    localparam int unsigned IDX_W    = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [IDX_W-1:0] r_idx;
    logic             r_c;
    logic [W-1:0]     r_a_sh;
    logic [W-1:0]     r_b_sh;
    logic [W-1:0]     r_out_sum;
    logic             r_out_carry;
    logic             r_out_valid;

    logic             w_accept;
    logic             w_busy;
    logic             w_last;
    logic [7:0]       w_byte;
    logic             w_c_nxt;

    assign w_accept = (r_state == S_IDLE) && in_valid;
    assign w_busy   = (r_state == S_BUSY);
    assign w_last   = w_busy && (r_idx == LAST_IDX);

    // csa_8 has no carry-in, so the running carry is added here; a 0xFF slice propagates it
    assign w_byte  = add_sum + 8'(r_c);
    assign w_c_nxt = add_carry | ((add_sum == 8'hFF) & r_c);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_state_nxt = S_BUSY;
            S_BUSY:  if (w_last)    w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default:                w_state_nxt = S_IDLE;
        endcase
    end

    // Operand shifters drain to zero after the last slice, so add_a/add_b idle at 0
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sh      <= '0;
            r_b_sh      <= '0;
            r_idx       <= '0;
            r_c         <= 1'b0;
            r_out_sum   <= '0;
            r_out_carry <= 1'b0;
        end else if (w_accept) begin
            r_a_sh <= in_a;
            r_b_sh <= in_b;
            r_idx  <= '0;
            r_c    <= 1'b0;
        end else if (w_busy) begin
            r_a_sh                  <= r_a_sh >> 8;
            r_b_sh                  <= r_b_sh >> 8;
            r_out_sum[8*r_idx +: 8] <= w_byte;
            r_c                     <= w_c_nxt;
            r_idx                   <= IDX_W'(r_idx + 1'b1);
            if (w_last) begin
                r_out_carry <= w_c_nxt;
            end
        end
    end

    // Result valid flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
        end else if (w_last) begin
            r_out_valid <= 1'b1;
        end else if ((r_state == S_DONE) && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = (r_state == S_IDLE) && !rst;
    assign add_a     = r_a_sh[7:0];
    assign add_b     = r_b_sh[7:0];
    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_carry = r_out_carry;

endmodule

// File: tb/tb_csa_byte_serial_add.sv
// Directed and randomized checks of csa_byte_serial_add with a behavioural csa_8 attached.
module tb_csa_byte_serial_add;

    localparam int unsigned N_BYTES = 4;
    localparam int unsigned W       = 8 * N_BYTES;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [7:0]   add_a;
    logic [7:0]   add_b;
    logic [7:0]   add_sum;
    logic         add_carry;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_carry;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Behavioural stand-in for the 8-bit carry-select adder
    assign {add_carry, add_sum} = 9'(add_a) + 9'(add_b);

    csa_byte_serial_add #(.N_BYTES(N_BYTES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_sum   (add_sum),
        .add_carry (add_carry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present operands, wait (bounded) for in_ready, return at the negedge after the accept edge
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        int k;
        k = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic get_result(input logic [W-1:0] exp_sum, input logic exp_carry, input string tag);
        int k;
        k = 0;
        out_ready = 1'b1;
        while (!out_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_out_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_sum"}, 64'(out_sum), 64'(exp_sum));
        check({tag, "_carry"}, 64'(out_carry), 64'(exp_carry));
        @(posedge clk);
        @(negedge clk);
        check({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] held_sum;
        logic [32:0]  exp_q[$];
        int           sent;
        int           recv;
        int           cyc;
        logic         fired;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_sum", 64'(out_sum), 64'd0);
        check("rst_out_carry", 64'(out_carry), 64'd0);
        check("rst_add_a", 64'(add_a), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", 64'(in_ready), 64'd1);

        // 1: carry ripples through every slice
        send(32'h0000_0001, 32'hFFFF_FFFF, "t1");
        get_result(32'h0000_0000, 1'b1, "t1");

        // 2: exact latency of 4 cycles from the accept edge
        send(32'h1234_5678, 32'h1111_1111, "t2");
        check("t2_lat0", 64'(out_valid), 64'd0);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("t2_lat%0d", i), 64'(out_valid), 64'd0);
        end
        @(negedge clk);
        check("t2_lat4", 64'(out_valid), 64'd1);
        get_result(32'h2345_6789, 1'b0, "t2");

        // 3: all-ones; first slice sees FE with carry, later slices FE plus carry-in
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, "t3");
        check("t3_add_a0", 64'(add_a), 64'hFF);
        check("t3_add_sum0", 64'(add_sum), 64'hFE);
        check("t3_add_carry0", 64'(add_carry), 64'd1);
        @(negedge clk);
        check("t3_add_sum1", 64'(add_sum), 64'hFE);
        get_result(32'hFFFF_FFFE, 1'b1, "t3");

        // 4: backpressure in DONE with new operands already offered
        out_ready = 1'b0;
        send(32'hA5A5_0F0F, 32'h0102_0304, "t4");
        repeat (4) @(negedge clk);
        check("t4_done_valid", 64'(out_valid), 64'd1);
        held_sum = out_sum;
        check("t4_first_sum", 64'(held_sum), 64'hA6A7_1213);
        in_valid = 1'b1;
        in_a     = 32'h0000_00FF;
        in_b     = 32'h0000_0001;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("t4_hold_valid%0d", i), 64'(out_valid), 64'd1);
            check($sformatf("t4_hold_sum%0d", i), 64'(out_sum), 64'(held_sum));
            check($sformatf("t4_hold_ready%0d", i), 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("t4_idle_valid", 64'(out_valid), 64'd0);
        check("t4_idle_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("t4_new_busy", 64'(in_ready), 64'd0);
        get_result(32'h0000_0100, 1'b0, "t4_new");

        // 5: reset during the second BUSY cycle discards the operation
        send(32'h8765_4321, 32'h1111_1111, "t5");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t5_rst_valid", 64'(out_valid), 64'd0);
        check("t5_rst_sum", 64'(out_sum), 64'd0);
        check("t5_rst_carry", 64'(out_carry), 64'd0);
        check("t5_rst_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("t5_idle_valid", 64'(out_valid), 64'd0);
        send(32'd200, 32'd100, "t5_post");
        get_result(32'd300, 1'b0, "t5_post");

        // 6: random operands with random handshakes, scoreboard in order
        sent  = 0;
        recv  = 0;
        cyc   = 0;
        fired = 1'b0;
        while (recv < 200 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (fired) begin
                in_valid = 1'b0;
                fired    = 1'b0;
            end
            if (!in_valid && sent < 200 && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1;
                in_a     = $urandom;
                in_b     = $urandom;
            end
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (in_valid && in_ready) begin
                exp_q.push_back({1'b0, in_a} + {1'b0, in_b});
                sent++;
                fired = 1'b1;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("rnd_unexpected_result", 64'(out_valid), 64'd0);
                end else begin
                    check($sformatf("rnd_result%0d", recv), 64'({out_carry, out_sum}),
                          64'(exp_q.pop_front()));
                end
                recv++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("rnd_recv_count", 64'(recv), 64'd200);
        check("rnd_leftover", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
